// File: rtl/matrix_key_scanner.sv
// ============================================================================
// matrix_key_scanner
// ----------------------------------------------------------------------------
// Reads a 4x4 matrix keypad. One row at a time is driven low, the active-low
// column inputs are sampled at the end of that row's time slot, and the four
// row samples together form a frame. Each frame is classified as NONE,
// SINGLE or MULTI. A debounce FSM only accepts a press or release once the
// same classification has been seen for DEBOUNCE_FRAMES frames in a row.
// Every accepted press produces one key_valid pulse.
//
// Ports
//   clk          in   1  system clock, all logic on the rising edge
//   rst          in   1  synchronous reset, active-high
//   col_i        in   4  column inputs, active-low (pulled up), asynchronous
//   row_o        out  4  row drive, active-low one-hot
//   key_code     out  4  last accepted key = {row[1:0], col[1:0]}
//   key_valid    out  1  one-cycle pulse when a press is accepted
//   key_pressed  out  1  high from accept until the release is accepted
//   multi_key    out  1  high if the last completed frame saw more than 1 key
// ============================================================================
module matrix_key_scanner #(
    parameter int F_CLK           = 50000000,
    parameter int F_SCAN          = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed,
    output logic       multi_key
);

    // One tick period is also the settle time for a newly driven row.
    localparam int TP     = F_CLK / F_SCAN;
    localparam int TICK_W = (TP > 1) ? $clog2(TP) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TP - 1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    // With a single-frame debounce the very first qualifying frame decides.
    localparam bit FIRST_FRAME_DECIDES = (DEBOUNCE_FRAMES <= 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAND    = 2'd1,
        PRESSED = 2'd2,
        REL     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [3:0]        col_meta;
    logic [3:0]        col_sync;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic [1:0]        row_ptr;
    logic [1:0]        next_ptr;

    // Keys seen so far in this frame, saturating at 2 (0, 1 or "many").
    logic [1:0]        acc_cnt;
    logic [3:0]        acc_code;

    logic [3:0]        row_keys;
    logic [2:0]        row_hits;
    logic [1:0]        row_col;
    logic [2:0]        hits_sum;
    logic [1:0]        next_cnt;
    logic [3:0]        next_code;
    logic              frame_end;
    frame_t            frame_res;

    state_t            state;
    logic [CNT_W-1:0]  deb_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [3:0]        cand;

    // ------------------------------------------------------------------
    // Two-flop synchronizer. Columns idle high, so reset to "no key".
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_i;
            col_sync <= col_meta;
        end
    end

    // ------------------------------------------------------------------
    // Row-step tick: fires on the last cycle of every TP-cycle slot.
    // ------------------------------------------------------------------
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Current-row decode. The lowest pressed column supplies the code; it
    // only matters when the whole frame ends up with exactly one key.
    // ------------------------------------------------------------------
    assign row_keys = ~col_sync;

    always_comb begin
        row_hits = '0;
        row_col  = '0;
        for (int c = 3; c >= 0; c--) begin
            if (row_keys[c]) begin
                row_hits = row_hits + 3'd1;
                row_col  = 2'(c);
            end
        end
    end

    // Merge this row into the frame accumulator (result used on tick only).
    assign hits_sum  = {1'b0, acc_cnt} + row_hits;
    assign next_cnt  = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    assign next_code = (acc_cnt == 2'd0) ? {row_ptr, row_col} : acc_code;
    assign frame_end = tick && (row_ptr == 2'd3);
    assign next_ptr  = row_ptr + 2'd1;

    always_comb begin
        frame_res = FR_NONE;
        if (next_cnt == 2'd1) begin
            frame_res = FR_SINGLE;
        end else if (next_cnt == 2'd2) begin
            frame_res = FR_MULTI;
        end
    end

    // ------------------------------------------------------------------
    // Row scanning and frame accumulation. The sample for a row is taken
    // on the same tick that moves the drive to the next row, so each row
    // has had a full tick period to settle before it is read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            row_ptr  <= 2'd0;
            row_o    <= 4'b1110;
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
        end else if (tick) begin
            row_ptr <= next_ptr;
            row_o   <= ~(4'b0001 << next_ptr);
            if (frame_end) begin
                acc_cnt  <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_cnt  <= next_cnt;
                acc_code <= next_code;
            end
        end
    end

    // Debounce counter increment that holds at the target instead of wrapping.
    assign cnt_inc = (deb_cnt >= CNT_TARGET) ? deb_cnt : (deb_cnt + CNT_ONE);

    // ------------------------------------------------------------------
    // Debounce FSM with registered outputs, stepped once per frame.
    // A different single key while a candidate is pending drops back to
    // IDLE rather than restarting on the new key, so a rolling press has
    // to settle before anything is reported.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            cand        <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                multi_key <= (frame_res == FR_MULTI);
                case (state)
                    IDLE: begin
                        if (frame_res == FR_SINGLE) begin
                            cand <= next_code;
                            if (FIRST_FRAME_DECIDES) begin
                                state       <= PRESSED;
                                deb_cnt     <= '0;
                                key_code    <= next_code;
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
                            end else begin
                                state   <= CAND;
                                deb_cnt <= CNT_ONE;
                            end
                        end
                    end

                    CAND: begin
                        if ((frame_res == FR_SINGLE) && (next_code == cand)) begin
                            if (cnt_inc >= CNT_TARGET) begin
                                state       <= PRESSED;
                                deb_cnt     <= '0;
                                key_code    <= cand;
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
                            end else begin
                                deb_cnt <= cnt_inc;
                            end
                        end else begin
                            state   <= IDLE;
                            deb_cnt <= '0;
                        end
                    end

                    PRESSED: begin
                        if (frame_res == FR_NONE) begin
                            if (FIRST_FRAME_DECIDES) begin
                                state       <= IDLE;
                                deb_cnt     <= '0;
                                key_pressed <= 1'b0;
                            end else begin
                                state   <= REL;
                                deb_cnt <= CNT_ONE;
                            end
                        end
                    end

                    REL: begin
                        if (frame_res == FR_NONE) begin
                            if (cnt_inc >= CNT_TARGET) begin
                                state       <= IDLE;
                                deb_cnt     <= '0;
                                key_pressed <= 1'b0;
                            end else begin
                                deb_cnt <= cnt_inc;
                            end
                        end else begin
                            // Contact bounce during release: still held.
                            state   <= PRESSED;
                            deb_cnt <= '0;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_key_scanner.sv
// ============================================================================
// tb_matrix_key_scanner
// ----------------------------------------------------------------------------
// Drives a keypad model onto the scanner and compares every cycle against a
// frame-level behavioural model: time since reset gives the scanned row, a
// three-deep key history accounts for the input synchronizer, and a run
// counter of matching frames decides press and release acceptance.
// Directed tests add literal expectations on top of the model.
// ============================================================================
module tb_matrix_key_scanner;

    localparam int TP = 10;
    localparam int DF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_i;
    logic [3:0] row_o;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;
    logic       multi_key;

    // Pressed keys, index = row*4 + col.
    logic [15:0] keys = '0;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_key_scanner #(
        .F_CLK(100),
        .F_SCAN(10),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .col_i(col_i),
        .row_o(row_o),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_pressed(key_pressed),
        .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    // Keypad: a column reads low when any driven-low row has that key pressed.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row_o[r] == 1'b0 && keys[r*4+c]) begin
                    col_i[c] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model, evaluated on the falling edge after each rising
    // edge. Stimulus only changes 2 time units after a rising edge, so the
    // values seen here are what the DUT inputs hold at the next rising edge.
    // ------------------------------------------------------------------
    int          m_k;
    logic [15:0] h1, h2, h3;
    int          acc_n;
    logic [3:0]  acc_c;
    bit          m_pressed;
    int          m_run;
    logic [3:0]  m_cand;
    logic [3:0]  m_code;
    bit          m_valid;
    bit          m_multi;
    bit          rst_prev    = 1'b1;
    bit          live        = 1'b0;
    int          pulse_count = 0;

    always @(negedge clk) begin : model
        int         r;
        logic [3:0] one_hot;
        logic [3:0] exp_row;
        if (rst_prev) begin
            m_k       = 0;
            acc_n     = 0;
            acc_c     = '0;
            m_pressed = 1'b0;
            m_run     = 0;
            m_cand    = '0;
            m_code    = '0;
            m_valid   = 1'b0;
            m_multi   = 1'b0;
            h1 = '0; h2 = '0; h3 = '0;
            live      = 1'b1;
        end else begin
            m_k++;
            m_valid = 1'b0;
            if (m_k % TP == 0) begin
                r = ((m_k / TP) - 1) % 4;
                // h3 is what the column inputs held three edges back,
                // i.e. what the synchronizer delivers at this tick.
                for (int c = 0; c < 4; c++) begin
                    if (h3[r*4+c]) begin
                        if (acc_n == 0) acc_c = 4'(r*4 + c);
                        acc_n++;
                    end
                end
                if (r == 3) begin
                    m_multi = (acc_n >= 2);
                    if (!m_pressed) begin
                        if (acc_n == 1 && (m_run == 0 || acc_c == m_cand)) begin
                            m_run++;
                            m_cand = acc_c;
                            if (m_run >= DF) begin
                                m_pressed = 1'b1;
                                m_code    = m_cand;
                                m_valid   = 1'b1;
                                m_run     = 0;
                            end
                        end else begin
                            m_run = 0;
                        end
                    end else begin
                        if (acc_n == 0) begin
                            m_run++;
                            if (m_run >= DF) begin
                                m_pressed = 1'b0;
                                m_run     = 0;
                            end
                        end else begin
                            m_run = 0;
                        end
                    end
                    acc_n = 0;
                end
            end
        end
        h3 = h2;
        h2 = h1;
        h1 = keys;
        rst_prev = rst;
        if (key_valid === 1'b1) pulse_count++;

        if (live) begin
            one_hot = 4'b0001;
            exp_row = ~(one_hot << ((m_k / TP) % 4));
            checkOutput("row_o", row_o, exp_row);
            checkOutput("key_code", key_code, m_code);
            checkOutput("key_valid", key_valid, m_valid);
            checkOutput("key_pressed", key_pressed, m_pressed);
            checkOutput("multi_key", multi_key, m_multi);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input bit v);
        keys[r*4+c] = v;
    endtask

    task automatic waitPressed(input logic val, input int budget,
                               input string name, output int lat);
        lat = 0;
        while (key_pressed !== val && lat < budget) begin
            stepCycles(1);
            lat++;
        end
        checkOutput(name, key_pressed, val);
    endtask

    logic [3:0] exp_rows [0:4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin : stimulus
        int lat;
        int p0;
        int waited;

        // Test 1: reset state and row rotation.
        rst  = 1'b1;
        keys = '0;
        stepCycles(5);
        checkOutput("t1_reset_row", row_o, 4'b1110);
        checkOutput("t1_reset_code", key_code, 4'h0);
        checkOutput("t1_reset_valid", key_valid, 1'b0);
        checkOutput("t1_reset_pressed", key_pressed, 1'b0);
        checkOutput("t1_reset_multi", multi_key, 1'b0);
        rst = 1'b0;
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            #1;
            if (k % 10 == 5) checkOutput("t1_row_seq", row_o, exp_rows[k/10]);
        end
        stepCycles(1);

        // Test 2: press (r2,c1) and hold for 400 cycles.
        p0 = pulse_count;
        applyStimulus(2, 1, 1'b1);
        waitPressed(1'b1, 170, "t2_press_timeout", lat);
        checkOutput("t2_press_latency", lat <= 163, 1'b1);
        stepCycles(400 - lat);
        checkOutput("t2_pulses", pulse_count - p0, 1);
        checkOutput("t2_code", key_code, 4'h9);
        checkOutput("t2_held", key_pressed, 1'b1);

        // Test 4: release, then press the same key again.
        applyStimulus(2, 1, 1'b0);
        waitPressed(1'b0, 170, "t4_release_timeout", lat);
        checkOutput("t4_release_latency", lat <= 163, 1'b1);
        stepCycles(20);
        p0 = pulse_count;
        applyStimulus(2, 1, 1'b1);
        waitPressed(1'b1, 170, "t4_repress_timeout", lat);
        stepCycles(60);
        checkOutput("t4_pulses", pulse_count - p0, 1);
        checkOutput("t4_code", key_code, 4'h9);
        applyStimulus(2, 1, 1'b0);
        waitPressed(1'b0, 170, "t4_release2_timeout", lat);
        stepCycles(20);

        // Test 3: bouncing (r1,c3) for 120 cycles, then held.
        p0 = pulse_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 3, (i % 2) == 0);
            stepCycles(15);
        end
        applyStimulus(1, 3, 1'b1);
        stepCycles(250);
        checkOutput("t3_pulses", pulse_count - p0, 1);
        checkOutput("t3_code", key_code, 4'h7);
        checkOutput("t3_held", key_pressed, 1'b1);
        applyStimulus(1, 3, 1'b0);
        waitPressed(1'b0, 170, "t3_release_timeout", lat);
        stepCycles(20);

        // Test 5: two keys together from IDLE.
        p0 = pulse_count;
        applyStimulus(0, 0, 1'b1);
        applyStimulus(3, 3, 1'b1);
        stepCycles(90);
        checkOutput("t5_multi_set", multi_key, 1'b1);
        stepCycles(200);
        checkOutput("t5_pulses", pulse_count - p0, 0);
        checkOutput("t5_not_pressed", key_pressed, 1'b0);
        checkOutput("t5_multi_held", multi_key, 1'b1);
        applyStimulus(0, 0, 1'b0);
        applyStimulus(3, 3, 1'b0);
        stepCycles(90);
        checkOutput("t5_multi_clear", multi_key, 1'b0);

        // Test 6: reset while a candidate has 2 matching frames.
        p0 = pulse_count;
        applyStimulus(3, 2, 1'b1);
        waited = 0;
        while (!(m_run == 2 && !m_pressed) && waited < 170) begin
            stepCycles(1);
            waited++;
        end
        checkOutput("t6_reach_cand", (m_run == 2 && !m_pressed), 1'b1);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        checkOutput("t6_rst_valid", key_valid, 1'b0);
        checkOutput("t6_rst_pressed", key_pressed, 1'b0);
        checkOutput("t6_rst_row", row_o, 4'b1110);
        checkOutput("t6_rst_code", key_code, 4'h0);
        checkOutput("t6_rst_multi", multi_key, 1'b0);
        checkOutput("t6_no_early_pulse", pulse_count - p0, 0);
        waitPressed(1'b1, 170, "t6_press_timeout", lat);
        stepCycles(10);
        checkOutput("t6_pulses", pulse_count - p0, 1);
        checkOutput("t6_code", key_code, 4'hE);
        applyStimulus(3, 2, 1'b0);
        stepCycles(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
